serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial add/subtract unit for the MiniMIPS datapath. It sequences one shared full-adder cell, built from two half_adder instances plus an OR, across WIDTH cycles. Operand and result shift registers are managed by a small FSM with a start/busy/done handshake. It serves as the area-minimal ALU add path and as a sequencing block for multi-cycle arithmetic.

Parameters:
WIDTH, 32, operand/result width in bits; legal range WIDTH >= 2.
CNT_W, $clog2(WIDTH), bit-counter width (derived, not overridden).

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request; sampled only when busy=0
sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse; result and flags valid
result  output  WIDTH  sum/difference; held until the next accepted start
carry_out  output  1  carry from MSB (for sub: 1 = no borrow)
overflow  output  1  signed overflow (carry into MSB XOR carry out of MSB)
zero  output  1  result == 0

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, result=0, carry_out=0, overflow=0, zero=0; internal shift regs, carry FF and counter cleared.
- FSM states: IDLE, RUN, DONE. busy=1 only in RUN; done=1 only in DONE.
- IDLE: if start=1 at an edge, do the following and go to RUN:
  - load A_sh=a and B_sh = sub ? ~b : b;
  - set carry FF = sub;
  - set count=0 and clear the result shift reg.
- If start=0 in IDLE, stay in IDLE.
- RUN, each edge:
  - bit = A_sh[0]^B_sh[0]^carry, formed through the half_adder pair;
  - result shift reg = {bit, res[WIDTH-1:1]};
  - A_sh and B_sh shift right by 1;
  - carry FF = full-adder carry;
  - count increments.
  - On the edge where count==WIDTH-2, latch the carry leaving that bit as c_msb_in (the carry into the MSB).
  - On the edge where count==WIDTH-1: go to DONE; carry_out = new carry; overflow = c_msb_in ^ new carry; zero = (final result==0).
- Latency: start is sampled at edge E0. done is high in the cycle following edge E0+WIDTH. Throughput is one operation per WIDTH+1 cycles.
- DONE: lasts exactly one cycle.
  - start=1 at this edge is accepted exactly as in IDLE (back-to-back operation), and state goes to RUN.
  - Otherwise state goes to IDLE.
- start while busy=1 is ignored; a, b and sub may change freely during RUN with no effect.
- result, carry_out, overflow and zero update only on RUN→DONE. They hold their values through IDLE and through the next RUN until that operation completes; they are never exposed partially shifted.
- All arithmetic is modulo 2^WIDTH; no sign extension.
- Reset asserted mid-RUN aborts the operation. No done pulse is produced, and outputs return to their reset values.

Test Plan:
WIDTH=8, a=0x0F, b=0x01, sub=0, start pulsed 1 cycle -> busy high 8 cycles; done pulses at start edge+8; result=0x10, carry_out=0, overflow=0, zero=0.
WIDTH=8, a=0xFF, b=0x01, sub=0 -> result=0x00, carry_out=1, overflow=0, zero=1; then a=0x7F, b=0x01 -> result=0x80, overflow=1, carry_out=0.
WIDTH=8, sub=1: a=0x05, b=0x07 -> result=0xFE, carry_out=0, overflow=0; a=0x80, b=0x01 -> result=0x7F, carry_out=1, overflow=1.
Mid-RUN after 3 cycles, start=1 with a=0x11, b=0x22 -> ignored; first op's result is unchanged and only one done pulse occurs. start held high through DONE -> second op accepted; its done arrives 9 cycles after the first done.
reset asserted asynchronously 4 cycles into RUN -> busy, done and result go to 0 immediately with no clock edge; no done follows; a new start afterwards completes normally.
WIDTH=32 default: a=0xFFFFFFFF, b=0x00000001 -> done at start edge+32; result=0, carry_out=1, zero=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract over WIDTH cycles with a start/busy/done handshake
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(WIDTH - 2);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic cy_q, cy_d, cmsb_q, cmsb_d, cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic s0, c0, sum, c1, fa_c;
  half_adder u_ha0 (.x(a_q[0]), .y(b_q[0]), .s(s0), .c(c0));
  half_adder u_ha1 (.x(s0), .y(cy_q), .s(sum), .c(c1));
  assign fa_c = c0 | c1;
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    cnt_d    = cnt_q;
    cy_d     = cy_q;
    cmsb_d   = cmsb_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    if (state_q != RUN && start) begin
      state_d = RUN;
      a_d     = a;
      b_d     = sub ? ~b : b;
      cy_d    = sub;
      cnt_d   = '0;
      res_d   = '0;
    end else if (state_q == RUN) begin
      res_d  = {sum, res_q[WIDTH-1:1]};
      a_d    = a_q >> 1;
      b_d    = b_q >> 1;
      cy_d   = fa_c;
      cnt_d  = cnt_q + 1'b1;
      cmsb_d = (cnt_q == PRE_LAST) ? fa_c : cmsb_q;
      // outputs are published only once the whole word has been formed
      if (cnt_q == LAST) begin
        state_d  = DONE;
        result_d = res_d;
        cout_d   = fa_c;
        ovf_d    = cmsb_q ^ fa_c;
        zero_d   = (res_d == '0);
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      cnt_q    <= '0;
      cy_q     <= 1'b0;
      cmsb_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      cnt_q    <= cnt_d;
      cy_q     <= cy_d;
      cmsb_q   <= cmsb_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of serial_adder_ctrl against an arithmetic model
module tb_serial_adder_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start8 = 1'b0, sub8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic busy8, done8, cout8, ovf8, zero8;
  logic [7:0] result8;
  logic start32 = 1'b0, sub32 = 1'b0;
  logic [31:0] a32 = '0, b32 = '0;
  logic busy32, done32, cout32, ovf32, zero32;
  logic [31:0] result32;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] prev_res = '0;
  logic [31:0] er;
  logic ec, ev, ez;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .sub(sub8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry_out(cout8),
    .overflow(ovf8), .zero(zero8)
  );

  serial_adder_ctrl dut32 (
    .clk(clk), .reset(reset), .start(start32), .sub(sub32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(result32), .carry_out(cout32),
    .overflow(ovf32), .zero(zero32)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                       output logic [31:0] r, output logic c, output logic v, output logic z);
    longint mask, ua, ub, sa, sb, t;
    mask = (longint'(1) << w) - 1;
    ua = longint'(a) & mask;
    ub = longint'(b) & mask;
    sa = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb = b[w-1] ? ub - (longint'(1) << w) : ub;
    r = 32'((s ? ua - ub : ua + ub) & mask);
    c = s ? (ua >= ub) : (ua + ub > mask);
    t = s ? sa - sb : sa + sb;
    v = (t < -(longint'(1) << (w - 1))) || (t >= (longint'(1) << (w - 1)));
    z = (r == 0);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic s);
    @(negedge clk);
    chk("idle_done", {31'b0, done8}, 32'd0);
    a8 = a; b8 = b; sub8 = s; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom);
      if (i == 2) start8 = 1'b1;
      if (i == 3) start8 = 1'b0;
      chk("busy_run", {31'b0, busy8}, 32'd1);
      chk("done_early", {31'b0, done8}, 32'd0);
      chk("result_hold", {24'b0, result8}, prev_res);
    end
    @(negedge clk);
    model(8, {24'b0, a}, {24'b0, b}, s, er, ec, ev, ez);
    chk("done_pulse", {31'b0, done8}, 32'd1);
    chk("busy_done", {31'b0, busy8}, 32'd0);
    chk("result", {24'b0, result8}, er);
    chk("carry_out", {31'b0, cout8}, {31'b0, ec});
    chk("overflow", {31'b0, ovf8}, {31'b0, ev});
    chk("zero", {31'b0, zero8}, {31'b0, ez});
    prev_res = er;
  endtask

  initial begin
    #12;
    chk("rst_busy", {31'b0, busy8}, 32'd0);
    chk("rst_done", {31'b0, done8}, 32'd0);
    chk("rst_result", {24'b0, result8}, 32'd0);
    chk("rst_flags", {29'b0, cout8, ovf8, zero8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    run8(8'h0F, 8'h01, 1'b0);
    run8(8'hFF, 8'h01, 1'b0);
    run8(8'h7F, 8'h01, 1'b0);
    run8(8'h05, 8'h07, 1'b1);
    run8(8'h80, 8'h01, 1'b1);
    run8(8'h00, 8'h00, 1'b1);
    run8(8'h80, 8'h80, 1'b0);
    for (int k = 0; k < 20; k++) run8(8'($urandom), 8'($urandom), 1'($urandom));
    // start during RUN is ignored; start held through DONE chains a second op
    @(negedge clk);
    a8 = 8'h40; b8 = 8'h05; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("mid_busy", {31'b0, busy8}, 32'd1);
      chk("mid_done", {31'b0, done8}, 32'd0);
      if (i == 3) begin start8 = 1'b1; a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; end
    end
    @(negedge clk);
    chk("mid_done1", {31'b0, done8}, 32'd1);
    chk("mid_res1", {24'b0, result8}, 32'h45);
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("b2b_busy", {31'b0, busy8}, 32'd1);
      chk("b2b_done", {31'b0, done8}, 32'd0);
      chk("b2b_hold", {24'b0, result8}, 32'h45);
    end
    @(negedge clk);
    chk("b2b_done2", {31'b0, done8}, 32'd1);
    chk("b2b_res2", {24'b0, result8}, 32'h33);
    // asynchronous reset four cycles into RUN
    @(negedge clk);
    a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_rst_busy", {31'b0, busy8}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy8}, 32'd0);
    chk("arst_done", {31'b0, done8}, 32'd0);
    chk("arst_result", {24'b0, result8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      chk("post_rst_done", {31'b0, done8}, 32'd0);
      chk("post_rst_busy", {31'b0, busy8}, 32'd0);
    end
    prev_res = '0;
    run8(8'h21, 8'h13, 1'b0);
    // default WIDTH=32
    @(negedge clk);
    a32 = 32'hFFFFFFFF; b32 = 32'h00000001; sub32 = 1'b0; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      chk("w32_busy", {31'b0, busy32}, 32'd1);
      chk("w32_early", {31'b0, done32}, 32'd0);
    end
    @(negedge clk);
    model(32, 32'hFFFFFFFF, 32'h00000001, 1'b0, er, ec, ev, ez);
    chk("w32_done", {31'b0, done32}, 32'd1);
    chk("w32_result", result32, er);
    chk("w32_carry", {31'b0, cout32}, {31'b0, ec});
    chk("w32_ovf", {31'b0, ovf32}, {31'b0, ev});
    chk("w32_zero", {31'b0, zero32}, {31'b0, ez});
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
